// File: rtl/com_fifo_out_path.sv
// Host COM receive path: 8N1 UART RX, length/CRC-8 framed packets into a
// byte FIFO, ACK/NAK on tx, and start/finish drain to the output stage.
module com_fifo_out_path #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 512,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       tx,
  input  logic       rx_enable,
  input  logic       out_enable,
  input  logic       out_finish,
  output logic [7:0] out_data,
  output logic       out_start,
  output logic [7:0] crc,
  output logic [3:0] error,
  output logic       rx_finish,
  output logic       out_idle,
  output logic [9:0] fifo_count,
  output logic       fifo_empty,
  output logic       fifo_full
);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam int TMO  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW   = $clog2(TMO + 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  typedef enum logic [2:0] {P_IDLE, P_PAYLOAD, P_CHECK, P_ACK, P_DONE} pk_st_t;
  typedef enum logic [1:0] {D_IDLE, D_READ, D_WAIT} dr_st_t;

  // CRC-8, poly 0x07, MSB first, one byte per call
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) x = x[7] ? ({x[6:0], 1'b0} ^ 8'h07) : {x[6:0], 1'b0};
    return x;
  endfunction

  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  rx_st_t        rst_q;
  logic [CW-1:0] rcnt_q;
  logic [2:0]    rbit_q;
  logic [7:0]    rsh_q, rx_byte_q;
  logic          rx_vld_q, rx_ferr_q;
  pk_st_t        pst_q;
  logic [8:0]    len_q;
  logic [7:0]    crc_calc_q, crc_q;
  logic [3:0]    error_q;
  logic          rx_finish_q, wr_q, tx_q, ack_ld_q;
  logic [7:0]    wr_data_q;
  logic [8:0]    tx_sh_q;
  logic [3:0]    tx_bits_q;
  logic [CW-1:0] tcnt_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [9:0]    cnt_q;
  dr_st_t        dst_q;
  logic [7:0]    out_data_q;
  logic          out_start_q;

  logic fall, rx_sof, tmo_hit, rd, we, ovf;
  assign fall       = rx_s3_q & ~rx_s2_q;
  assign rx_sof     = (rst_q == R_IDLE) & fall;
  assign tmo_hit    = (tmo_q == TW'(TMO - 1));
  assign fifo_empty = (cnt_q == 10'd0);
  assign fifo_full  = (cnt_q == 10'(DEPTH));
  assign rd         = (dst_q == D_IDLE) & out_enable & ~fifo_empty;
  assign we         = wr_q & (~fifo_full | rd);
  assign ovf        = wr_q & fifo_full & ~rd;

  assign tx = tx_q;  assign out_data = out_data_q;  assign out_start = out_start_q;
  assign crc = crc_q;  assign error = error_q;  assign rx_finish = rx_finish_q;
  assign fifo_count = cnt_q;
  assign out_idle = (dst_q == D_IDLE) & fifo_empty;

  // 2-flop synchronizer plus one delay stage for falling-edge detection
  always_ff @(posedge clk or negedge reset)
    if (!reset) {rx_s1_q, rx_s2_q, rx_s3_q} <= 3'b111;
    else        {rx_s1_q, rx_s2_q, rx_s3_q} <= {rx, rx_s1_q, rx_s2_q};

  // UART byte receiver: edge start, mid-bit sampling, accept at mid-stop
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rst_q <= R_IDLE; rcnt_q <= '0; rbit_q <= '0; rsh_q <= '0;
      rx_byte_q <= '0; rx_vld_q <= 1'b0; rx_ferr_q <= 1'b0;
    end else begin
      rx_vld_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      case (rst_q)
        R_IDLE:  if (fall) begin rcnt_q <= '0; rst_q <= R_START; end
        R_START: if (rcnt_q == CW'(HALF - 1)) begin
                   rcnt_q <= '0; rbit_q <= '0;
                   rst_q  <= rx_s2_q ? R_IDLE : R_DATA;  // glitch: not a real start bit
                 end else rcnt_q <= rcnt_q + 1'b1;
        R_DATA:  if (rcnt_q == CW'(CLKS_PER_BIT - 1)) begin
                   rcnt_q <= '0;
                   rsh_q  <= {rx_s2_q, rsh_q[7:1]};
                   if (rbit_q == 3'd7) rst_q <= R_STOP;
                   rbit_q <= rbit_q + 1'b1;
                 end else rcnt_q <= rcnt_q + 1'b1;
        default: if (rcnt_q == CW'(CLKS_PER_BIT - 1)) begin
                   rcnt_q <= '0;
                   rst_q  <= R_IDLE;
                   if (rx_s2_q) begin rx_vld_q <= 1'b1; rx_byte_q <= rsh_q; end
                   else rx_ferr_q <= 1'b1;
                 end else rcnt_q <= rcnt_q + 1'b1;
      endcase
    end

  // Inter-byte timeout, restarted by each start bit while inside a packet
  always_ff @(posedge clk or negedge reset)
    if (!reset) tmo_q <= '0;
    else if (!(pst_q == P_PAYLOAD || pst_q == P_CHECK) || rx_sof || tmo_hit) tmo_q <= '0;
    else tmo_q <= tmo_q + 1'b1;

  // Packet FSM: length, payload into FIFO, CRC check, ACK/NAK transmit
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pst_q <= P_IDLE; len_q <= '0; crc_calc_q <= '0; crc_q <= '0; error_q <= '0;
      rx_finish_q <= 1'b0; wr_q <= 1'b0; wr_data_q <= '0; tx_q <= 1'b1; ack_ld_q <= 1'b0;
      tx_sh_q <= '1; tx_bits_q <= '0; tcnt_q <= '0;
    end else begin
      wr_q <= 1'b0;
      if (ovf) error_q[1] <= 1'b1;
      case (pst_q)
        P_IDLE:
          if (rx_enable && rx_vld_q) begin
            error_q <= '0; rx_finish_q <= 1'b0; crc_calc_q <= '0;
            len_q <= (rx_byte_q == 8'd0) ? 9'd256 : {1'b0, rx_byte_q};
            pst_q <= P_PAYLOAD;
          end else if (rx_enable && rx_ferr_q) begin
            error_q <= 4'b0001; rx_finish_q <= 1'b0; pst_q <= P_ACK; ack_ld_q <= 1'b1;
          end
        P_PAYLOAD, P_CHECK:
          if (rx_ferr_q) begin
            error_q[0] <= 1'b1; pst_q <= P_ACK; ack_ld_q <= 1'b1;
          end else if (tmo_hit) begin
            error_q[3] <= 1'b1; pst_q <= P_ACK; ack_ld_q <= 1'b1;
          end else if (rx_vld_q && pst_q == P_PAYLOAD) begin
            crc_calc_q <= crc8_byte(crc_calc_q, rx_byte_q);
            wr_q <= 1'b1; wr_data_q <= rx_byte_q;
            len_q <= len_q - 9'd1;
            if (len_q == 9'd1) pst_q <= P_CHECK;
          end else if (rx_vld_q) begin
            if (rx_byte_q != crc_calc_q) error_q[2] <= 1'b1;
            crc_q <= crc_calc_q; pst_q <= P_ACK; ack_ld_q <= 1'b1;
          end
        P_ACK:
          if (ack_ld_q) begin
            // start bit goes out now; shift reg holds data then stop
            ack_ld_q <= 1'b0; tx_q <= 1'b0; tcnt_q <= '0; tx_bits_q <= 4'd9;
            tx_sh_q <= {1'b1, (error_q == 4'd0) ? 8'h06 : 8'h15};
          end else if (tcnt_q == CW'(CLKS_PER_BIT - 1)) begin
            tcnt_q <= '0;
            if (tx_bits_q == 4'd0) begin pst_q <= P_DONE; rx_finish_q <= 1'b1; end
            else begin
              tx_q <= tx_sh_q[0]; tx_sh_q <= {1'b1, tx_sh_q[8:1]};
              tx_bits_q <= tx_bits_q - 4'd1;
            end
          end else tcnt_q <= tcnt_q + 1'b1;
        default:
          if (rx_sof || !rx_enable) pst_q <= P_IDLE;
      endcase
    end

  // FIFO storage (contents are don't-care once count is cleared)
  always_ff @(posedge clk)
    if (we) mem[wptr_q] <= wr_data_q;

  // FIFO pointers/occupancy and drain handshake FSM
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr_q <= '0; rptr_q <= '0; cnt_q <= '0;
      dst_q <= D_IDLE; out_data_q <= '0; out_start_q <= 1'b0;
    end else begin
      if (we) wptr_q <= wptr_q + 1'b1;
      if (rd) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + {9'd0, we} - {9'd0, rd};
      case (dst_q)
        D_IDLE: if (rd) begin out_data_q <= mem[rptr_q]; out_start_q <= 1'b1; dst_q <= D_READ; end
        D_READ: begin out_start_q <= 1'b0; dst_q <= D_WAIT; end
        default: if (out_finish) dst_q <= D_IDLE;
      endcase
    end
endmodule

// File: tb/tb_com_fifo_out_path.sv
// Directed bench for com_fifo_out_path: UART packet stimulus, tx ACK decoder,
// byte-queue model of FIFO contents checked on every out_start.
module tb_com_fifo_out_path;
  localparam int CPB = 16;

  logic clk = 1'b0, reset = 1'b0;
  logic rx = 1'b1, rx2 = 1'b1, rx_enable = 1'b1, out_enable = 1'b0, out_finish = 1'b0;
  logic out_enable2 = 1'b0, out_finish2 = 1'b0;
  logic tx, out_start, rx_finish, out_idle, fifo_empty, fifo_full;
  logic [7:0] out_data, crc;  logic [3:0] error;  logic [9:0] fifo_count;
  logic tx2, out_start2, rx_finish2, out_idle2, fifo_empty2, fifo_full2;
  logic [7:0] out_data2, crc2;  logic [3:0] error2;  logic [9:0] fifo_count2;

  int vecs = 0, errs = 0, nstart = 0, kick_req = 0, kick_done = 0;
  bit resp_en = 1'b1;
  logic [7:0] mq[$];            // model: bytes expected in main FIFO, in order
  logic [7:0] aq0[$], aq1[$];   // decoded ACK bytes per DUT
  logic [7:0] pbuf [16];

  always #5 clk = ~clk;

  com_fifo_out_path #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx), .rx_enable(rx_enable),
    .out_enable(out_enable), .out_finish(out_finish), .out_data(out_data),
    .out_start(out_start), .crc(crc), .error(error), .rx_finish(rx_finish),
    .out_idle(out_idle), .fifo_count(fifo_count), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full));

  com_fifo_out_path #(.CLKS_PER_BIT(CPB), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .rx(rx2), .tx(tx2), .rx_enable(rx_enable),
    .out_enable(out_enable2), .out_finish(out_finish2), .out_data(out_data2),
    .out_start(out_start2), .crc(crc2), .error(error2), .rx_finish(rx_finish2),
    .out_idle(out_idle2), .fifo_count(fifo_count2), .fifo_empty(fifo_empty2),
    .fifo_full(fifo_full2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // bitwise CRC-8 (poly 0x07) over pbuf[0..n-1]
  function automatic logic [7:0] crc8(input int n);
    logic [7:0] c = 8'h00;
    logic fb;
    for (int i = 0; i < n; i++)
      for (int j = 7; j >= 0; j--) begin
        fb = c[7] ^ pbuf[i][j];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    return c;
  endfunction

  task automatic drive(input bit sel, input logic v);
    if (sel) rx2 = v; else rx = v;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input bit stop);
    drive(sel, 1'b0); repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin drive(sel, b[i]); repeat (CPB) @(negedge clk); end
    drive(sel, stop); repeat (CPB) @(negedge clk);
    drive(sel, 1'b1); repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_pkt(input bit sel, input int n, input logic [7:0] crcb, input bit push);
    send_byte(sel, 8'(n), 1'b1);
    for (int i = 0; i < n; i++) begin
      if (push) mq.push_back(pbuf[i]);
      send_byte(sel, pbuf[i], 1'b1);
    end
    send_byte(sel, crcb, 1'b1);
  endtask

  task automatic wait_fin(input bit sel, input int budget);
    int n = 0;
    while (!(sel ? rx_finish2 : rx_finish) && n < budget) begin @(negedge clk); n++; end
    chk("rx_finish_wait", 32'(sel ? rx_finish2 : rx_finish), 32'd1);
  endtask

  task automatic chk_ack(input bit sel, input logic [7:0] exp);
    int sz = sel ? aq1.size() : aq0.size();
    chk("ack_count", sz, 1);
    if (sz > 0) chk("ack_byte", sel ? aq1.pop_front() : aq0.pop_front(), exp);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!out_idle && n < budget) begin @(negedge clk); n++; end
    chk("drain_idle", out_idle, 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_tx", tx, 1);          chk("rst_out_data", out_data, 0);
    chk("rst_out_start", out_start, 0); chk("rst_crc", crc, 0);
    chk("rst_error", error, 0);    chk("rst_rx_finish", rx_finish, 0);
    chk("rst_count", fifo_count, 0); chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0); chk("rst_out_idle", out_idle, 1);
    chk("rst_count4", fifo_count2, 0);
  endtask

  // ACK decoder on each tx line: sample mid-bit, LSB first
  task automatic mon(input bit sel);
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if ((sel ? tx2 : tx) == 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        if ((sel ? tx2 : tx) == 1'b0) begin
          for (int i = 0; i < 8; i++) begin repeat (CPB) @(negedge clk); b[i] = sel ? tx2 : tx; end
          repeat (CPB) @(negedge clk);
          if (sel) aq1.push_back(b); else aq0.push_back(b);
        end
      end
    end
  endtask
  initial mon(1'b0);
  initial mon(1'b1);

  // downstream: answer out_start with out_finish 5 cycles later; kicks force one pulse
  always @(negedge clk) begin
    if (out_start && resp_en) begin
      repeat (5) @(negedge clk);
      out_finish = 1'b1; @(negedge clk); out_finish = 1'b0;
    end else if (kick_req != kick_done) begin
      kick_done = kick_req;
      out_finish = 1'b1; @(negedge clk); out_finish = 1'b0;
    end
  end

  // per-cycle compare against model and flag definitions
  always @(negedge clk) begin
    chk("empty_flag", fifo_empty, 32'(fifo_count == 10'd0));
    chk("full_flag", fifo_full, 32'(fifo_count == 10'd512));
    chk("full_flag4", fifo_full2, 32'(fifo_count2 == 10'd4));
    chk("out_start4", out_start2, 0);
    if (out_start) begin
      nstart++;
      if (mq.size() == 0) chk("unexpected_out_start", 1, 0);
      else chk("out_data", out_data, mq.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete, got timeout expected finish");
    errs++;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $fatal(1);
  end

  initial begin
    int s0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // good packet 03 01 02 03 48
    pbuf[0] = 8'h01; pbuf[1] = 8'h02; pbuf[2] = 8'h03;
    send_pkt(0, 3, 8'h48, 1);
    wait_fin(0, 1000);
    chk("A_crc_lit", crc, 8'h48); chk("A_crc_model", crc, crc8(3));
    chk("A_error", error, 0); chk("A_count", fifo_count, 3); chk_ack(0, 8'h06);

    // drain 01 02 03
    out_enable = 1'b1;
    wait_idle(300);
    chk("A_drained", nstart, 3); chk("A_mq_empty", mq.size(), 0);
    out_enable = 1'b0;

    // same payload, wrong CRC byte
    send_pkt(0, 3, 8'h00, 1);
    wait_fin(0, 1000);
    chk("B_error", error, 4'b0100); chk("B_count", fifo_count, 3);
    chk("B_crc", crc, 8'h48); chk_ack(0, 8'h15);

    // out_finish held low: exactly one read then stall
    resp_en = 1'b0; s0 = nstart; out_enable = 1'b1;
    repeat (100) @(negedge clk);
    chk("stall_reads", nstart - s0, 1); chk("stall_count", fifo_count, 2);
    chk("stall_idle", out_idle, 0);
    resp_en = 1'b1; kick_req++;
    wait_idle(300);
    chk("stall_drained", nstart - s0, 3);
    out_enable = 1'b0;

    // framing error on first payload byte, then a clean packet
    send_byte(0, 8'h03, 1'b1);
    send_byte(0, 8'hAA, 1'b0);
    wait_fin(0, 1000);
    chk("F_error", error, 4'b0001); chk_ack(0, 8'h15); chk("F_count", fifo_count, 0);
    pbuf[0] = 8'h0A; pbuf[1] = 8'h0B;
    send_pkt(0, 2, crc8(2), 1);
    wait_fin(0, 1000);
    chk("C_error", error, 0); chk("C_crc", crc, crc8(2));
    chk_ack(0, 8'h06); chk("C_count", fifo_count, 2);

    // rx_enable low: traffic ignored
    rx_enable = 1'b0;
    pbuf[0] = 8'h77;
    send_pkt(0, 1, crc8(1), 0);
    repeat (300) @(negedge clk);
    chk("dis_ack", aq0.size(), 0); chk("dis_count", fifo_count, 2);
    rx_enable = 1'b1;
    repeat (4) @(negedge clk);

    // timeout after one of two payload bytes
    send_byte(0, 8'h02, 1'b1);
    mq.push_back(8'h5A);
    send_byte(0, 8'h5A, 1'b1);
    wait_fin(0, 3000);
    chk("T_error", error, 4'b1000); chk_ack(0, 8'h15); chk("T_count", fifo_count, 3);

    // DEPTH=4 instance: 6-byte packet overflows
    for (int i = 0; i < 6; i++) pbuf[i] = 8'(8'h11 + i);
    send_pkt(1, 6, crc8(6), 0);
    wait_fin(1, 1000);
    chk("O_count", fifo_count2, 4); chk("O_full", fifo_full2, 1);
    chk("O_error", error2, 4'b0010); chk_ack(1, 8'h15);

    // drain the main FIFO: 0A 0B 5A
    out_enable = 1'b1;
    wait_idle(300);
    chk("D_mq_empty", mq.size(), 0);
    out_enable = 1'b0;

    // reset in the middle of a payload
    send_byte(0, 8'h04, 1'b1);
    send_byte(0, 8'h21, 1'b1);
    send_byte(0, 8'h22, 1'b1);
    chk("R_pre_count", fifo_count, 2);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    pbuf[0] = 8'h55;
    send_pkt(0, 1, crc8(1), 1);
    wait_fin(0, 1000);
    chk("R_error", error, 0); chk("R_crc", crc, crc8(1));
    chk_ack(0, 8'h06); chk("R_count", fifo_count, 1);
    out_enable = 1'b1;
    wait_idle(300);
    chk("R_mq_empty", mq.size(), 0);
    out_enable = 1'b0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
